// File: rtl/mips_multicycle_ctrl_if.sv
// Control and memory-handshake bundle between the multicycle MIPS controller and its datapath.
// The controller drives the mux selects and strobes; the datapath returns opcode and mem_ready.
interface mips_multicycle_ctrl_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_write;
  logic       i_or_d;
  logic       ir_write;
  logic       pc_write;
  logic       branch;
  logic [1:0] pc_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;

  modport master (
    input  opcode, mem_ready,
    output mem_req, mem_write, i_or_d, ir_write, pc_write, branch, pc_src,
           alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg
  );

  modport slave (
    output opcode, mem_ready,
    input  mem_req, mem_write, i_or_d, ir_write, pc_write, branch, pc_src,
           alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Main sequencing FSM for the multicycle MIPS datapath, with memory stall handshake
// and a wrapping retired-instruction counter.
//
// state    | meaning
// FETCH    | read instruction at PC, PC += 4 when memory completes
// DECODE   | read registers, precompute branch target
// MEMADR   | effective address for lw/sw
// MEMRD    | data read, wait for memory
// MEMWB    | load result into rt
// MEMWR    | data write, wait for memory
// EXECUTE  | R-type ALU operation
// ALUWB    | R-type result into rd
// BRANCH   | beq compare and conditional PC load
// ADDIEX   | addi ALU operation
// ADDIWB   | addi result into rt
// JUMP     | PC <= jump target
module mips_multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mips_multicycle_ctrl_if.master bus,
  output logic                 illegal_op,
  output logic                 instr_retired,
  output logic [CNT_W-1:0]     instr_count,
  output logic [3:0]           state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  state_t state;
  logic   legal_op;

  assign legal_op  = bus.opcode inside {OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW};
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_FETCH;
      instr_count <= '0;
    end else begin
      if (instr_retired)
        instr_count <= instr_count + CNT_W'(1);
      case (state)
        S_FETCH:   if (bus.mem_ready) state <= S_DECODE;
        S_DECODE: begin
          case (bus.opcode)
            OP_LW, OP_SW: state <= S_MEMADR;
            OP_RTYPE:     state <= S_EXECUTE;
            OP_BEQ:       state <= S_BRANCH;
            OP_ADDI:      state <= S_ADDIEX;
            OP_J:         state <= S_JUMP;
            default:      state <= S_FETCH;
          endcase
        end
        // opcode is still held by the instruction register here
        S_MEMADR:  state <= (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:   if (bus.mem_ready) state <= S_MEMWB;
        S_MEMWR:   if (bus.mem_ready) state <= S_FETCH;
        S_EXECUTE: state <= S_ALUWB;
        S_ADDIEX:  state <= S_ADDIWB;
        default:   state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    bus.mem_req    = 1'b0;
    bus.mem_write  = 1'b0;
    bus.i_or_d     = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.branch     = 1'b0;
    bus.pc_src     = 2'b00;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.alu_op     = 2'b00;
    bus.reg_write  = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    illegal_op     = 1'b0;
    instr_retired  = 1'b0;
    if (rst_n) begin
      case (state)
        S_FETCH: begin
          bus.mem_req   = 1'b1;
          bus.alu_src_b = 2'b01;
          bus.ir_write  = bus.mem_ready;
          bus.pc_write  = bus.mem_ready;
        end
        S_DECODE: begin
          bus.alu_src_b = 2'b11;
          illegal_op    = !legal_op;
        end
        S_MEMADR: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'b10;
        end
        S_MEMRD: begin
          bus.mem_req = 1'b1;
          bus.i_or_d  = 1'b1;
        end
        S_MEMWB: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = 1'b1;
          instr_retired  = 1'b1;
        end
        S_MEMWR: begin
          bus.mem_req   = 1'b1;
          bus.mem_write = 1'b1;
          bus.i_or_d    = 1'b1;
          instr_retired = bus.mem_ready;
        end
        S_EXECUTE: begin
          bus.alu_src_a = 1'b1;
          bus.alu_op    = 2'b10;
        end
        S_ALUWB: begin
          bus.reg_write = 1'b1;
          bus.reg_dst   = 1'b1;
          instr_retired = 1'b1;
        end
        S_BRANCH: begin
          bus.alu_src_a = 1'b1;
          bus.alu_op    = 2'b01;
          bus.branch    = 1'b1;
          bus.pc_src    = 2'b01;
          instr_retired = 1'b1;
        end
        S_ADDIEX: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'b10;
        end
        S_ADDIWB: begin
          bus.reg_write = 1'b1;
          instr_retired = 1'b1;
        end
        S_JUMP: begin
          bus.pc_write  = 1'b1;
          bus.pc_src    = 2'b10;
          instr_retired = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: directed vector table, random instruction stream against
// an instruction-level model, and a counter wrap / mid-instruction reset sequence.
module tb_mips_multicycle_ctrl;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       branch;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal_op;
    logic       instr_retired;
  } ctl_t;

  typedef struct packed {
    logic        rst;
    logic [5:0]  op;
    logic        mr;
    logic [3:0]  st;
    ctl_t        ctl;
    logic [31:0] cnt;
  } vec_t;

  localparam logic [5:0] LW = 6'h23, SW = 6'h2B, RT = 6'h00, BEQ = 6'h04, ADDI = 6'h08, JMP = 6'h02;

  localparam ctl_t C_ZERO    = '0;
  localparam ctl_t C_FETCH_S = '{mem_req:1'b1, alu_src_b:2'b01, default:'0};
  localparam ctl_t C_FETCH_R = '{mem_req:1'b1, ir_write:1'b1, pc_write:1'b1, alu_src_b:2'b01, default:'0};
  localparam ctl_t C_DECODE  = '{alu_src_b:2'b11, default:'0};
  localparam ctl_t C_ILLEGAL = '{alu_src_b:2'b11, illegal_op:1'b1, default:'0};
  localparam ctl_t C_MEMADR  = '{alu_src_a:1'b1, alu_src_b:2'b10, default:'0};
  localparam ctl_t C_MEMRD   = '{mem_req:1'b1, i_or_d:1'b1, default:'0};
  localparam ctl_t C_MEMWB   = '{reg_write:1'b1, mem_to_reg:1'b1, instr_retired:1'b1, default:'0};
  localparam ctl_t C_MEMWR_S = '{mem_req:1'b1, mem_write:1'b1, i_or_d:1'b1, default:'0};
  localparam ctl_t C_MEMWR_R = '{mem_req:1'b1, mem_write:1'b1, i_or_d:1'b1, instr_retired:1'b1, default:'0};
  localparam ctl_t C_EXEC    = '{alu_src_a:1'b1, alu_op:2'b10, default:'0};
  localparam ctl_t C_ALUWB   = '{reg_write:1'b1, reg_dst:1'b1, instr_retired:1'b1, default:'0};
  localparam ctl_t C_BRANCH  = '{alu_src_a:1'b1, alu_op:2'b01, branch:1'b1, pc_src:2'b01, instr_retired:1'b1, default:'0};
  localparam ctl_t C_ADDIEX  = '{alu_src_a:1'b1, alu_src_b:2'b10, default:'0};
  localparam ctl_t C_ADDIWB  = '{reg_write:1'b1, instr_retired:1'b1, default:'0};
  localparam ctl_t C_JUMP    = '{pc_write:1'b1, pc_src:2'b10, instr_retired:1'b1, default:'0};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        ill32, ret32, ill4, ret4;
  logic [31:0] cnt32;
  logic [3:0]  cnt4;
  logic [3:0]  st32, st4;
  ctl_t        act32, act4;

  int checks = 0;
  int errors = 0;

  mips_multicycle_ctrl_if b32();
  mips_multicycle_ctrl_if b4();

  assign b32.opcode = opcode;
  assign b32.mem_ready = mem_ready;
  assign b4.opcode = opcode;
  assign b4.mem_ready = mem_ready;

  mips_multicycle_ctrl #(.CNT_W(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .bus(b32), .illegal_op(ill32),
    .instr_retired(ret32), .instr_count(cnt32), .state_dbg(st32)
  );

  mips_multicycle_ctrl #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus(b4), .illegal_op(ill4),
    .instr_retired(ret4), .instr_count(cnt4), .state_dbg(st4)
  );

  assign act32 = {b32.mem_req, b32.mem_write, b32.i_or_d, b32.ir_write, b32.pc_write, b32.branch,
                  b32.pc_src, b32.alu_src_a, b32.alu_src_b, b32.alu_op, b32.reg_write, b32.reg_dst,
                  b32.mem_to_reg, ill32, ret32};
  assign act4  = {b4.mem_req, b4.mem_write, b4.i_or_d, b4.ir_write, b4.pc_write, b4.branch,
                  b4.pc_src, b4.alu_src_a, b4.alu_src_b, b4.alu_op, b4.reg_write, b4.reg_dst,
                  b4.mem_to_reg, ill4, ret4};

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Instruction-level model: each instruction is a list of steps; memory steps
  // hold until mem_ready, the last step retires the instruction.
  int          seq[5];
  int          len;
  int          idx;
  bit          ill;
  logic [31:0] mcnt;
  logic [5:0]  cur_op;
  logic [5:0]  plan_op;

  task automatic new_instr(input logic [5:0] op);
    cur_op = op;
    ill = 1'b0;
    case (op)
      LW:      begin seq = '{0, 1, 2, 3, 4};  len = 5; end
      SW:      begin seq = '{0, 1, 2, 5, 0};  len = 4; end
      RT:      begin seq = '{0, 1, 6, 7, 0};  len = 4; end
      BEQ:     begin seq = '{0, 1, 8, 0, 0};  len = 3; end
      ADDI:    begin seq = '{0, 1, 9, 10, 0}; len = 4; end
      JMP:     begin seq = '{0, 1, 11, 0, 0}; len = 3; end
      default: begin seq = '{0, 1, 0, 0, 0};  len = 2; ill = 1'b1; end
    endcase
  endtask

  function automatic ctl_t step_ctl(input int ph, input bit mr, input bit bad);
    case (ph)
      0:       return mr ? C_FETCH_R : C_FETCH_S;
      1:       return bad ? C_ILLEGAL : C_DECODE;
      2:       return C_MEMADR;
      3:       return C_MEMRD;
      4:       return C_MEMWB;
      5:       return mr ? C_MEMWR_R : C_MEMWR_S;
      6:       return C_EXEC;
      7:       return C_ALUWB;
      8:       return C_BRANCH;
      9:       return C_ADDIEX;
      10:      return C_ADDIWB;
      11:      return C_JUMP;
      default: return C_ZERO;
    endcase
  endfunction

  function automatic logic [5:0] pick_op();
    logic [5:0] legal[6] = '{LW, SW, RT, BEQ, ADDI, JMP};
    if ($urandom_range(0, 9) < 8) return legal[$urandom_range(0, 5)];
    return 6'($urandom_range(0, 63));
  endfunction

  task automatic step(input bit rst, input bit mr);
    ctl_t exp_ctl;
    int   ph;
    ph = seq[idx];
    rst_n = rst;
    opcode = cur_op;
    mem_ready = mr;
    @(negedge clk);
    exp_ctl = rst ? step_ctl(ph, mr, ill) : C_ZERO;
    chk("state", 64'(st32), 64'(ph));
    chk("ctl", 64'(act32), 64'(exp_ctl));
    chk("count", 64'(cnt32), 64'(mcnt));
    chk("ctl_w4", 64'(act4), 64'(exp_ctl));
    chk("count_w4", 64'(cnt4), 64'(mcnt[3:0]));
    @(posedge clk);
    #1;
    if (!rst) begin
      idx = 0;
      mcnt = '0;
      new_instr(plan_op);
    end else if (!(ph == 0 || ph == 3 || ph == 5) || mr) begin
      if (idx == len - 1) begin
        if (!ill) mcnt = mcnt + 1;
        idx = 0;
        new_instr(plan_op);
      end else begin
        idx++;
      end
    end
  endtask

  vec_t vecs[$];

  task automatic add(input logic r, input logic [5:0] o, input logic m, input logic [3:0] s,
                     input ctl_t c, input logic [31:0] n);
    vecs.push_back('{r, o, m, s, c, n});
  endtask

  initial begin
    for (int i = 0; i < 3; i++) add(0, LW, 1, 0, C_ZERO, 0);
    add(1, LW, 1, 0, C_FETCH_R, 0);  add(1, LW, 1, 1, C_DECODE, 0);
    add(1, LW, 1, 2, C_MEMADR, 0);   add(1, LW, 1, 3, C_MEMRD, 0);
    add(1, LW, 1, 4, C_MEMWB, 0);
    add(1, SW, 1, 0, C_FETCH_R, 1);  add(1, SW, 1, 1, C_DECODE, 1);
    add(1, SW, 0, 2, C_MEMADR, 1);   add(1, SW, 0, 5, C_MEMWR_S, 1);
    add(1, SW, 0, 5, C_MEMWR_S, 1);  add(1, SW, 1, 5, C_MEMWR_R, 1);
    add(1, RT, 1, 0, C_FETCH_R, 2);  add(1, RT, 1, 1, C_DECODE, 2);
    add(1, RT, 0, 6, C_EXEC, 2);     add(1, RT, 1, 7, C_ALUWB, 2);
    add(1, BEQ, 1, 0, C_FETCH_R, 3); add(1, BEQ, 1, 1, C_DECODE, 3);
    add(1, BEQ, 1, 8, C_BRANCH, 3);
    add(1, ADDI, 1, 0, C_FETCH_R, 4); add(1, ADDI, 1, 1, C_DECODE, 4);
    add(1, ADDI, 1, 9, C_ADDIEX, 4);  add(1, ADDI, 1, 10, C_ADDIWB, 4);
    add(1, JMP, 1, 0, C_FETCH_R, 5); add(1, JMP, 1, 1, C_DECODE, 5);
    add(1, JMP, 1, 11, C_JUMP, 5);
    add(1, 6'h3F, 1, 0, C_FETCH_R, 6); add(1, 6'h3F, 1, 1, C_ILLEGAL, 6);
    add(1, LW, 0, 0, C_FETCH_S, 6);  add(1, LW, 1, 0, C_FETCH_R, 6);
    add(1, LW, 1, 1, C_DECODE, 6);   add(1, LW, 1, 2, C_MEMADR, 6);
    add(1, LW, 0, 3, C_MEMRD, 6);    add(1, LW, 1, 3, C_MEMRD, 6);
    add(1, LW, 0, 4, C_MEMWB, 6);    add(1, LW, 0, 0, C_FETCH_S, 7);

    rst_n = 1'b0;
    opcode = LW;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      rst_n = vecs[i].rst;
      opcode = vecs[i].op;
      mem_ready = vecs[i].mr;
      @(negedge clk);
      chk("vec_state", 64'(st32), 64'(vecs[i].st));
      chk("vec_ctl", 64'(act32), 64'(vecs[i].ctl));
      chk("vec_count", 64'(cnt32), 64'(vecs[i].cnt));
      chk("vec_count_w4", 64'(cnt4), 64'(vecs[i].cnt[3:0]));
      @(posedge clk);
      #1;
    end

    // Table leaves both counters at 7 with the controller stalled in FETCH.
    idx = 0;
    mcnt = 32'd7;
    plan_op = pick_op();
    new_instr(plan_op);
    for (int c = 0; c < 3000; c++) begin
      plan_op = pick_op();
      step($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0);
    end

    plan_op = JMP;
    step(0, 1);
    for (int c = 0; c < 44; c++) step(1, 1);
    plan_op = LW;
    step(1, 1);
    chk("preload_w4", 64'(cnt4), 64'd15);
    step(1, 1);
    step(1, 1);
    step(1, 1);
    plan_op = JMP;
    step(0, 0);
    chk("abort_state", 64'(st32), 64'd0);
    chk("abort_count", 64'(cnt32), 64'd0);
    chk("abort_count_w4", 64'(cnt4), 64'd0);
    for (int c = 0; c < 45; c++) step(1, 1);
    chk("count15_w4", 64'(cnt4), 64'd15);
    for (int c = 0; c < 3; c++) step(1, 1);
    chk("wrap_w4", 64'(cnt4), 64'd0);
    chk("wrap_count", 64'(cnt32), 64'd16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
